bram_portb_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the peripheral-side port B of the shared 16-bit BRAM. CPU owns port A.
- Up to NUM_REQ peripheral requesters share port B, one transaction at a time. Requesters include the Pong VGA fetch, paddle input writer and score logic.
- Drives addr_b, data_b and we_b as registered outputs.
- Captures q_b and returns it to the winning requester with a one-cycle ack.

---
 rtl/bram_portb_arbiter.sv | 128 ++++++++++++
 tb/tb_bram_portb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_portb_arbiter.sv
// Round-robin arbiter/sequencer for BRAM port B: one peripheral transaction at a time,
// IDLE -> ISSUE -> (WAIT on reads) -> RESP, with a one-cycle ack back to the winner.
module bram_portb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [2:0]                    grant_id,
  output logic                          busy,
  output logic [ADDR_WIDTH-1:0]         addr_b,
  output logic [DATA_WIDTH-1:0]         data_b,
  output logic                          we_b,
  input  logic [DATA_WIDTH-1:0]         q_b
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             ptr_q, ptr_d;
  logic [2:0]             grant_id_q, grant_id_d;
  logic [ADDR_WIDTH-1:0]  addr_b_q, addr_b_d;
  logic [DATA_WIDTH-1:0]  data_b_q, data_b_d;
  logic                   we_b_q, we_b_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   busy_q, busy_d;

  logic [2*NUM_REQ-1:0]   req_rot;
  logic                   found;
  logic [2:0]             win;
  logic [NUM_REQ-1:0]     win_oh;

  // Rotate so bit 0 is the pointer's requester; first set bit wins.
  always_comb begin
    req_rot = {req, req} >> ptr_q;
    found   = 1'b0;
    win     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        win   = 3'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
    win_oh = NUM_REQ'(1) << win;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    addr_b_d   = addr_b_q;
    data_b_d   = data_b_q;
    we_b_d     = 1'b0;
    ack_d      = '0;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          addr_b_d   = ADDR_WIDTH'(req_addr >> (int'(win) * ADDR_WIDTH));
          data_b_d   = DATA_WIDTH'(req_wdata >> (int'(win) * DATA_WIDTH));
          we_b_d     = |(req_we & win_oh);
          grant_id_d = win;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (we_b_q) begin
          ack_d   = NUM_REQ'(1) << grant_id_q;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        rdata_d = q_b;
        ack_d   = NUM_REQ'(1) << grant_id_q;
        state_d = RESP;
      end
      RESP: begin
        ptr_d   = (int'(grant_id_q) == NUM_REQ - 1) ? 3'd0 : grant_id_q + 3'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      addr_b_q   <= '0;
      data_b_q   <= '0;
      we_b_q     <= 1'b0;
      ack_q      <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      addr_b_q   <= addr_b_d;
      data_b_q   <= data_b_d;
      we_b_q     <= we_b_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
    end
  end

  // The BRAM samples we_b on the same edge that applies reset; masking here keeps an
  // aborted ISSUE-cycle write from landing in memory.
  assign we_b     = we_b_q & ~reset;
  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign addr_b   = addr_b_q;
  assign data_b   = data_b_q;
endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Bench for bram_portb_arbiter: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against a transaction-level round-robin model.
module tb_bram_portb_arbiter;
  localparam int N = 4, AW = 16, DW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0, req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata, data_b, q_b;
  logic [2:0]      grant_id;
  logic            busy, we_b;
  logic [AW-1:0]   addr_b;

  logic [DW-1:0]   mem [0:65535];
  logic [DW-1:0]   smem [0:31];
  logic            pl_we = 1'b0;
  logic [AW-1:0]   pl_addr = '0;
  logic [DW-1:0]   pl_data = '0;

  int n_vec = 0, n_err = 0;

  bram_portb_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .grant_id(grant_id), .busy(busy),
    .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b)
  );

  always #5 clk = ~clk;

  // Synchronous BRAM port B, plus a bench-side preload path
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (we_b) mem[addr_b] <= data_b;
    q_b <= mem[addr_b];
  end

  typedef struct {
    int          id;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic on, input logic we,
                         input logic [15:0] a, input logic [15:0] d);
    req[i] = on;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ack(output logic [N-1:0] a);
    int cyc;
    cyc = 0;
    a = '0;
    while (a == '0 && cyc < 12) begin
      @(negedge clk);
      cyc++;
      a = ack;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, wes;
    logic [N-1:0] a;
    @(negedge clk);
    set_req(v.id, 1'b1, v.we, v.addr, v.wdata);
    cyc = 0; wes = 0; a = '0;
    while (a == '0 && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (we_b) wes++;
      if (cyc == 1) begin
        check("issue_addr", addr_b, v.addr);
        if (v.we) check("issue_data", data_b, v.wdata);
      end
      a = ack;
    end
    set_req(v.id, 1'b0, 1'b0, '0, '0);
    check("ack", a, 32'(1 << v.id));
    check("latency", cyc, v.exp_lat);
    check("we_count", wes, 32'(v.we));
    check("grant_id", grant_id, v.id);
    if (!v.we) check("rdata", rdata, v.exp_rdata);
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Random-phase model state
  int            e, arb_e, g_e, ack_e, ptr, gw, pick, got, acks;
  logic          wwe;
  logic [15:0]   waddr, wdat, last_addr, last_data, last_rd;
  int            last_gid;
  bit            pend [N];
  logic [N-1:0]  cur_req, cur_we, exp_ack, a;
  logic [N*AW-1:0] cur_addr;
  logic [N*DW-1:0] cur_wd;

  initial begin
    tbl[0] = '{0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 3};
    tbl[1] = '{2, 1'b1, 16'h0123, 16'h5A5A, 16'h0000, 2};
    tbl[2] = '{0, 1'b0, 16'h0123, 16'h0000, 16'h5A5A, 3};
    tbl[3] = '{3, 1'b0, 16'h0002, 16'h0000, 16'h0007, 3};
    tbl[4] = '{3, 1'b1, 16'hFFFF, 16'h1234, 16'h0000, 2};
    tbl[5] = '{1, 1'b0, 16'hFFFF, 16'h0000, 16'h1234, 3};
    tbl[6] = '{1, 1'b1, 16'h0000, 16'hFFFF, 16'h0000, 2};
    tbl[7] = '{2, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 3};

    // Preload while held in reset
    preload(16'h0040, 16'hBEEF);
    preload(16'h0002, 16'h0007);
    preload(16'h0010, 16'h1111);
    for (int i = 0; i < 32; i++) begin
      smem[i] = 16'hA000 + 16'(i);
      preload(16'h0200 + 16'(i), 16'hA000 + 16'(i));
    end

    @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", addr_b, 0);
    check("rst_data", data_b, 0);
    check("rst_we", we_b, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Round-robin: all four requesting from reset
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 16'h0200 + 16'(i), 16'h0);
    got = 0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        check("rr_order", ack, 32'(1 << (got % N)));
        got++;
      end
    end
    check("rr_count", got, 5);
    req = '0;

    // Priority rotation: after requester 1, 3 beats 0
    do_reset();
    set_req(1, 1'b1, 1'b0, 16'h0201, 16'h0);
    wait_ack(a);
    check("rot_first", a, 4'b0010);
    set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(0, 1'b1, 1'b0, 16'h0200, 16'h0);
    set_req(3, 1'b1, 1'b0, 16'h0203, 16'h0);
    wait_ack(a);
    check("rot_second", a, 4'b1000);
    set_req(3, 1'b0, 1'b0, 16'h0, 16'h0);
    wait_ack(a);
    check("rot_third", a, 4'b0001);
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Reset during the ISSUE cycle of a write
    @(negedge clk);
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, 16'h0010, 16'hDEAD);
    @(negedge clk);
    check("mid_rst_issue_we", we_b, 1);
    reset = 1'b1;
    set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_we", we_b, 0);
    check("mid_rst_addr", addr_b, 0);
    check("mid_rst_data", data_b, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_grant", grant_id, 0);
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ack != '0) acks++;
    end
    check("mid_rst_no_ack", acks, 0);
    check("mid_rst_mem", mem[16'h0010], 16'h1111);

    // Requester drops req during WAIT; transaction still completes
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 16'h0002, 16'h0);
    @(negedge clk);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    check("drop_ack", ack, 4'b0001);
    check("drop_rdata", rdata, 16'h0007);
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ack != '0) acks++;
    end
    check("drop_no_reack", acks, 0);
    check("drop_idle", busy, 0);

    // Randomized traffic vs transaction-level model
    do_reset();
    e = 0; arb_e = 1; g_e = -10; ack_e = -10; ptr = 0; gw = 0; wwe = 1'b0;
    waddr = '0; wdat = '0; last_addr = '0; last_data = '0; last_rd = '0; last_gid = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int c = 0; c < 800; c++) begin
      cur_req = req; cur_we = req_we; cur_addr = req_addr; cur_wd = req_wdata;
      @(negedge clk);
      e++;
      if (e == arb_e) begin
        pick = rr_pick(cur_req, ptr);
        if (pick < 0) arb_e = e + 1;
        else begin
          gw = pick;
          wwe = cur_we[gw];
          waddr = cur_addr[gw*AW +: AW];
          wdat = cur_wd[gw*DW +: DW];
          g_e = e;
          ack_e = e + (wwe ? 1 : 2);
          arb_e = ack_e + 2;
          ptr = (gw + 1) % N;
          last_addr = waddr; last_data = wdat; last_gid = gw;
        end
      end
      exp_ack = (e == ack_e) ? N'(1 << gw) : '0;
      if (e == ack_e && !wwe) last_rd = smem[waddr[4:0]];
      check("rnd_ack", ack, exp_ack);
      check("rnd_busy", busy, (e >= g_e && e <= ack_e));
      check("rnd_we", we_b, (e == g_e && wwe));
      check("rnd_addr", addr_b, last_addr);
      check("rnd_data", data_b, last_data);
      check("rnd_grant", grant_id, last_gid);
      check("rnd_rdata", rdata, last_rd);
      if (e == ack_e && wwe) smem[waddr[4:0]] = wdat;
      for (int i = 0; i < N; i++) begin
        if (exp_ack[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          set_req(i, 1'b1, 1'($urandom_range(1)), 16'h0200 + 16'($urandom_range(31)),
                  16'($urandom));
        end else if (!pend[i]) begin
          set_req(i, 1'b0, 1'b0, 16'h0, 16'h0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
